// File: rtl/fl_collector.sv
// fl_collector: merges INPUT_COUNT FrameLink streams onto one output with
// frame-atomic round-robin arbitration and a combinational data path.
module fl_collector #(
    parameter int DATA_WIDTH  = 64,
    parameter int DREM_WIDTH  = 3,
    parameter int INPUT_COUNT = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [INPUT_COUNT*DATA_WIDTH-1:0] RX_DATA,
    input  logic [INPUT_COUNT*DREM_WIDTH-1:0] RX_REM,
    input  logic [INPUT_COUNT-1:0]            RX_SOF_N,
    input  logic [INPUT_COUNT-1:0]            RX_EOF_N,
    input  logic [INPUT_COUNT-1:0]            RX_SOP_N,
    input  logic [INPUT_COUNT-1:0]            RX_EOP_N,
    input  logic [INPUT_COUNT-1:0]            RX_SRC_RDY_N,
    output logic [INPUT_COUNT-1:0]            RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]             TX_DATA,
    output logic [DREM_WIDTH-1:0]             TX_REM,
    output logic                              TX_SOF_N,
    output logic                              TX_EOF_N,
    output logic                              TX_SOP_N,
    output logic                              TX_EOP_N,
    output logic                              TX_SRC_RDY_N,
    input  logic                              TX_DST_RDY_N
);
    localparam int GW = $clog2(INPUT_COUNT);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
    logic [GW-1:0] req_port;
    logic          req_hit;
    logic          tx_last;

    // Port index p+k wrapped modulo INPUT_COUNT (works for non-power-of-two counts).
    function automatic logic [GW-1:0] next_port(input logic [GW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return GW'(s >= INPUT_COUNT ? s - INPUT_COUNT : s);
    endfunction

    // Scan downwards so the port closest to ptr, in cyclic order, is the one kept.
    always_comb begin
        req_hit  = 1'b0;
        req_port = ptr_q;
        for (int k = INPUT_COUNT - 1; k >= 0; k--) begin
            if (!RX_SRC_RDY_N[next_port(ptr_q, k)]) begin
                req_hit  = 1'b1;
                req_port = next_port(ptr_q, k);
            end
        end
    end

    always_comb begin
        TX_DATA      = '0;
        TX_REM       = '0;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (state_q == S_LOCKED && gnt_q == GW'(i)) begin
                TX_DATA         = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                TX_REM          = RX_REM[i*DREM_WIDTH +: DREM_WIDTH];
                TX_SOF_N        = RX_SOF_N[i];
                TX_EOF_N        = RX_EOF_N[i];
                TX_SOP_N        = RX_SOP_N[i];
                TX_EOP_N        = RX_EOP_N[i];
                TX_SRC_RDY_N    = RX_SRC_RDY_N[i];
                RX_DST_RDY_N[i] = TX_DST_RDY_N;
            end
        end
    end

    assign tx_last = !TX_SRC_RDY_N && !TX_DST_RDY_N && !TX_EOF_N;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        if (state_q == S_IDLE && req_hit) begin
            state_d = S_LOCKED;
            gnt_d   = req_port;
        end
        if (state_q == S_LOCKED && tx_last) begin
            state_d = S_IDLE;
            ptr_d   = next_port(gnt_q, 1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_fl_collector.sv
// tb_fl_collector: randomized FrameLink sources, a transaction-level arbitration
// model feeding a scoreboard, and a monitor comparing every TX word and handshake.
module tb_fl_collector;
    localparam int DW = 64;
    localparam int RW = 3;
    localparam int N  = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic [3:0]    f;
    } word_t;

    typedef struct packed {
        logic         src;
        logic [N-1:0] dst;
        logic         idle;
    } hs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N*DW-1:0] rx_data;
    logic [N*RW-1:0] rx_rem;
    logic [N-1:0] rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_n, rx_dst_n;
    logic [DW-1:0] tx_data;
    logic [RW-1:0] tx_rem;
    logic tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_n;
    logic tx_dst_n = 1'b1;

    fl_collector #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .INPUT_COUNT(N)) dut (
        .CLK(clk), .RESET(rst),
        .RX_DATA(rx_data), .RX_REM(rx_rem),
        .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
        .RX_SRC_RDY_N(rx_src_n), .RX_DST_RDY_N(rx_dst_n),
        .TX_DATA(tx_data), .TX_REM(tx_rem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_n), .TX_DST_RDY_N(tx_dst_n)
    );

    always #5 clk = ~clk;

    word_t cur_w[N];
    int cur_len[N], cur_idx[N], gap[N];
    logic [N-1:0] active = '0, src_off = '1, xfer;
    int frames[N][$];
    int bp = 0;
    int tmo = 0;
    logic done = 1'b0;
    int total = 0, bad = 0;

    int m_ptr = 0, m_gnt = 0;
    logic m_lock = 1'b0;
    word_t exp_q[$];
    hs_t hs_q[$];

    task automatic apply();
        for (int p = 0; p < N; p++) begin
            rx_data[p*DW +: DW] = cur_w[p].d;
            rx_rem[p*RW +: RW]  = cur_w[p].r;
            {rx_sof_n[p], rx_eof_n[p], rx_sop_n[p], rx_eop_n[p]} = cur_w[p].f;
            rx_src_n[p] = src_off[p];
        end
    endtask

    task automatic new_word(input int p);
        cur_w[p].d    = {8'(p), 24'($urandom), 32'($urandom)};
        cur_w[p].r    = RW'($urandom);
        cur_w[p].f[3] = !(cur_idx[p] == 0);
        cur_w[p].f[2] = !(cur_idx[p] == cur_len[p] - 1);
        cur_w[p].f[1] = cur_w[p].f[3] ? 1'($urandom) : 1'b0;
        cur_w[p].f[0] = cur_w[p].f[2] ? 1'($urandom) : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (xfer[p] && active[p]) begin
                cur_idx[p]++;
                if (cur_idx[p] == cur_len[p]) active[p] = 1'b0;
                else new_word(p);
            end
            if (!active[p] && frames[p].size() > 0) begin
                cur_len[p] = frames[p].pop_front();
                cur_idx[p] = 0;
                active[p]  = 1'b1;
                new_word(p);
            end
            src_off[p] = !active[p] || ($urandom_range(99) < gap[p]);
        end
        tx_dst_n = $urandom_range(99) < bp;
        apply();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            active[p]  = 1'b0;
            src_off[p] = 1'b1;
            frames[p].delete();
        end
        apply();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic busy();
        logic b;
        b = m_lock || (active != '0);
        for (int p = 0; p < N; p++) b = b || (frames[p].size() > 0);
        return b;
    endfunction

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) tmo++;
        repeat (3) step();
    endtask

    always @(negedge clk) xfer = ~rx_src_n & ~rx_dst_n;

    // Reference: one frame at a time, next owner is the first requester at or after ptr.
    always @(negedge clk) begin
        hs_t h;
        int k;
        h.src  = m_lock ? rx_src_n[m_gnt] : 1'b1;
        h.dst  = '1;
        if (m_lock) h.dst[m_gnt] = tx_dst_n;
        h.idle = !m_lock;
        hs_q.push_back(h);
        if (m_lock) begin
            if (!rx_src_n[m_gnt] && !tx_dst_n) begin
                exp_q.push_back({rx_data[m_gnt*DW +: DW], rx_rem[m_gnt*RW +: RW],
                                 rx_sof_n[m_gnt], rx_eof_n[m_gnt], rx_sop_n[m_gnt], rx_eop_n[m_gnt]});
                if (!rx_eof_n[m_gnt]) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_gnt + 1) % N;
                end
            end
        end else begin
            k = 0;
            while (k < N && rx_src_n[(m_ptr + k) % N]) k++;
            if (k < N) begin
                m_gnt  = (m_ptr + k) % N;
                m_lock = 1'b1;
            end
        end
        if (rst) begin
            m_lock = 1'b0;
            m_ptr  = 0;
            m_gnt  = 0;
        end
    end

    always @(negedge clk) begin
        hs_t h;
        word_t g, e;
        #1;
        if (hs_q.size() > 0) begin
            h = hs_q.pop_front();
            total++;
            if (tx_src_n !== h.src || rx_dst_n !== h.dst) begin
                bad++;
                $display("FAIL handshake t=%0t got src_n=%b dst_n=%b want src_n=%b dst_n=%b",
                         $time, tx_src_n, rx_dst_n, h.src, h.dst);
            end
            if (h.idle) begin
                total++;
                if ({tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n} !== {{DW{1'b0}}, {RW{1'b0}}, 4'hF}) begin
                    bad++;
                    $display("FAIL idle_out t=%0t got data=%h rem=%h flags=%b%b%b%b want zeros/1111",
                             $time, tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n);
                end
            end
        end
        if (!tx_src_n && !tx_dst_n) begin
            total++;
            g = {tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_extra t=%0t got %h want no transfer", $time, g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL tx_word t=%0t got %h want %h", $time, g, e);
                end
            end
        end
        if (done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL lost_words got %0d pending want 0", exp_q.size());
            end
            total++;
            if (tmo != 0) begin
                bad++;
                $display("FAIL timeout got %0d expired waits want 0", tmo);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int c;
        for (int p = 0; p < N; p++) begin
            cur_w[p] = {{DW{1'b0}}, {RW{1'b0}}, 4'hF};
            gap[p]   = 0;
        end
        apply();
        do_reset(3);
        repeat (10) step();
        // all ports offer back-to-back 3-word frames with no stalls
        for (int p = 0; p < N; p++) repeat (3) frames[p].push_back(3);
        drain(500);
        // port 2 five words with gaps and backpressure, port 3 waiting behind it
        gap[2] = 30;
        bp = 50;
        frames[2].push_back(5);
        frames[3].push_back(1);
        c = 0;
        while (!(m_lock && m_gnt == 2) && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) tmo++;
        frames[0].push_back(1);
        drain(500);
        // mid-frame reset on port 1, then a scan that must restart at port 0
        gap[2] = 0;
        bp = 0;
        frames[1].push_back(4);
        c = 0;
        while (cur_idx[1] != 2 && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) tmo++;
        do_reset(1);
        frames[3].push_back(2);
        frames[0].push_back(2);
        drain(200);
        frames[1].push_back(2);
        frames[2].push_back(2);
        drain(200);
        // random soak
        for (int p = 0; p < N; p++) gap[p] = $urandom_range(40);
        bp = 30;
        for (int it = 0; it < 200; it++) begin
            frames[$urandom_range(N - 1)].push_back($urandom_range(1, 6));
            step();
        end
        drain(20000);
        done = 1'b1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fl_collector.md
# fl_collector

FrameLink N-to-1 collector: merges `INPUT_COUNT` FrameLink input streams into one FrameLink output with frame-atomic round-robin arbitration. It is the inverse of the FrameLink distributor: it sits where several per-channel FrameLink streams must be serialised onto a single FrameLink bus. Frames are never interleaved; a granted input owns the output from its SOF word through its EOF word.

## Interface
- `DATA_WIDTH`, 64, FrameLink data width in bits; allowed values 8, 16, 32, 64, 128.
- `DREM_WIDTH`, 3, REM width; must equal log2(`DATA_WIDTH`/8), minimum 1.
- `INPUT_COUNT`, 4, number of RX ports; allowed range 2..16.
- `CLK`  in  1  single clock; all logic is rising-edge.
- `RESET`  in  1  synchronous, active-high reset.
- `RX_DATA`  in  `INPUT_COUNT`*`DATA_WIDTH`  input data; port i occupies bits [(i+1)*`DATA_WIDTH`-1 : i*`DATA_WIDTH`].
- `RX_REM`  in  `INPUT_COUNT`*`DREM_WIDTH`  input REM, packed the same way.
- `RX_SOF_N`, `RX_EOF_N`, `RX_SOP_N`, `RX_EOP_N`  in  `INPUT_COUNT`  per-port frame and part delimiters, active-low.
- `RX_SRC_RDY_N`  in  `INPUT_COUNT`  per-port source ready, active-low.
- `RX_DST_RDY_N`  out  `INPUT_COUNT`  per-port destination ready, active-low.
- `TX_DATA`  out  `DATA_WIDTH`, `TX_REM`  out  `DREM_WIDTH`  output data and REM.
- `TX_SOF_N`, `TX_EOF_N`, `TX_SOP_N`, `TX_EOP_N`  out  1  output delimiters, active-low.
- `TX_SRC_RDY_N`  out  1  output source ready, active-low.
- `TX_DST_RDY_N`  in  1  output destination ready, active-low.

## Operation
- State: FSM {IDLE, LOCKED}, grant register `gnt` (log2 `INPUT_COUNT` bits), round-robin pointer `ptr` (same width).
- A word transfers on port p when `RX_SRC_RDY_N`(p)=0 and `RX_DST_RDY_N`(p)=0. On TX it transfers when `TX_SRC_RDY_N`=0 and `TX_DST_RDY_N`=0.
- IDLE: `TX_SRC_RDY_N`=1 and all `RX_DST_RDY_N`=1. The arbiter scans ports `ptr`, `ptr`+1, … modulo `INPUT_COUNT`. The first port with `RX_SRC_RDY_N`=0 is loaded into `gnt`, and the FSM moves to LOCKED on the next edge. If no port requests, the FSM stays in IDLE.
- LOCKED: combinational passthrough of port `gnt`:
  - `TX_DATA`/`TX_REM`/`TX_*_N` = RX fields of `gnt`.
  - `TX_SRC_RDY_N` = `RX_SRC_RDY_N`(`gnt`).
  - `RX_DST_RDY_N`(`gnt`) = `TX_DST_RDY_N`; every other port's `RX_DST_RDY_N` = 1.
- LOCKED -> IDLE on a TX transfer with `TX_EOF_N`=0. On that edge `ptr` <= `gnt`+1 modulo `INPUT_COUNT`; wrap from `INPUT_COUNT`-1 to 0.
- Single-word frame (SOF_N=EOF_N=0 in the same word): locked for exactly one transfer cycle.
- No protocol checking. Words are forwarded as presented, including a first word lacking SOF_N. Delimiters are never altered.
- Data muxing is combinational; the only storage is FSM, `gnt` and `ptr`.
- Output fields other than `TX_SRC_RDY_N` are don't-care while `TX_SRC_RDY_N`=1.

## Timing
- Reset (`RESET`=1 at an edge): FSM=IDLE, `gnt`=0, `ptr`=0. From that edge: `TX_SRC_RDY_N`=1 and all `RX_DST_RDY_N`=1; `TX_SOF_N`/`TX_EOF_N`/`TX_SOP_N`/`TX_EOP_N` read 1, `TX_DATA`/`TX_REM` read 0.
- Reset mid-frame: the lock is dropped at that edge and the output frame is truncated. Upstream is responsible for its own reset. After reset the next grant starts at port 0.
- Latency in LOCKED: 0 cycles, RX word to TX word in the same cycle.
- Arbitration bubble: one idle cycle (IDLE) between the EOF transfer of one frame and the first word of the next. Peak throughput is L/(L+1) words per cycle for frames of L words.
- Backpressure: `TX_DST_RDY_N`=1 stalls the granted port only; the lock is held indefinitely. Source gaps (`RX_SRC_RDY_N`(`gnt`)=1 mid-frame) hold the lock.
- Simultaneous requests in IDLE: the lowest port at or after `ptr`, in cyclic order, wins. Requests from other ports do not affect LOCKED.
- A port that deasserts `RX_SRC_RDY_N` before being locked loses nothing. It is re-evaluated every IDLE cycle.

## Test plan
- Reset and idle: `RESET`=1 for 3 cycles, then no requests -> `TX_SRC_RDY_N`=1 and `RX_DST_RDY_N`="1111" every cycle; FSM stays IDLE.
- Fairness: `INPUT_COUNT`=4, all ports continuously offer 3-word frames, `TX_DST_RDY_N`=0 -> output frame source order 0,1,2,3,0,1…; each frame is 3 contiguous words followed by exactly 1 bubble cycle; no interleaving.
- Backpressure and gaps: port 2 sends a 5-word frame while `TX_DST_RDY_N` toggles with a random 50% duty and port 2 inserts 2 source-gap cycles -> all 5 words out in order with identical DATA/REM/delimiters. Port 3 requests throughout but gets `RX_DST_RDY_N`(3)=1 until the cycle after port 2's EOF transfer.
- Wrap and single-word frames: `ptr`=3, ports 3 and 0 each offer a 1-word frame (SOF_N=EOF_N=0) -> port 3 forwarded first, then port 0 after one bubble; `ptr` ends at 1.
- Reset mid-frame: port 1 has transferred 2 of 4 words, then `RESET`=1 for 1 cycle -> `TX_SRC_RDY_N`=1 and all `RX_DST_RDY_N`=1 from that edge. If ports 1 and 2 then request, port 1 is granted first (`ptr`=0 scan).
- Scoreboard for every scenario: per-source FIFO of RX transfers compared against TX transfers; frame sequence attributed by grant; zero mismatches and no lost words.
